// File: rtl/hazard_pipe_tracker.sv
// Pipeline metadata tracker: carries register addresses and write enables from
// decode through EX/MEM/WB, detects load-use hazards and counts stall cycles.
module hazard_pipe_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_Dest,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_Valid,
  input  logic                  Flush,
  output logic [REG_ADDR_W-1:0] EX_Rs,
  output logic [REG_ADDR_W-1:0] EX_Rt,
  output logic [REG_ADDR_W-1:0] MEM_Dest,
  output logic [REG_ADDR_W-1:0] WB_Dest,
  output logic                  MEM_RegWrite,
  output logic                  WB_RegWrite,
  output logic                  Stall,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic [CNT_W-1:0]      Stall_Count
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic                  wb_rw_q, wb_rw_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_s;
  logic                  bubble_s;

  // Load-use hazard detection; a flush kills the consumer so no stall is needed
  always_comb begin
    stall_s = ex_mr_q & ex_valid_q & ID_Valid & ~Flush & (ex_dest_q != ZERO_REG) &
              ((ex_dest_q == ID_Rs) | (ID_UsesRt & (ex_dest_q == ID_Rt)));
    bubble_s = stall_s | Flush;
  end

  // Next-state for the stage registers and the saturating stall counter
  always_comb begin
    ex_rs_d    = ZERO_REG;
    ex_rt_d    = ZERO_REG;
    ex_dest_d  = ZERO_REG;
    ex_rw_d    = 1'b0;
    ex_mr_d    = 1'b0;
    ex_valid_d = 1'b0;
    if (!bubble_s) begin
      ex_rs_d    = ID_Rs;
      ex_rt_d    = ID_Rt;
      ex_dest_d  = ID_Dest;
      ex_rw_d    = ID_RegWrite & ID_Valid & (ID_Dest != ZERO_REG);
      ex_mr_d    = ID_MemRead & ID_Valid;
      ex_valid_d = ID_Valid;
    end else begin
      ex_valid_d = 1'b0;
    end
    mem_dest_d = ex_dest_q;
    mem_rw_d   = ex_rw_q;
    wb_dest_d  = mem_dest_q;
    wb_rw_d    = mem_rw_q;
    if (stall_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs_q    <= ZERO_REG;
      ex_rt_q    <= ZERO_REG;
      ex_dest_q  <= ZERO_REG;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_valid_q <= 1'b0;
      mem_dest_q <= ZERO_REG;
      mem_rw_q   <= 1'b0;
      wb_dest_q  <= ZERO_REG;
      wb_rw_q    <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_dest_q  <= ex_dest_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      ex_valid_q <= ex_valid_d;
      mem_dest_q <= mem_dest_d;
      mem_rw_q   <= mem_rw_d;
      wb_dest_q  <= wb_dest_d;
      wb_rw_q    <= wb_rw_d;
      cnt_q      <= cnt_d;
    end
  end

  // Forwarding compares addresses only, so non-writing stages report register 0
  assign EX_Rs        = ex_rs_q;
  assign EX_Rt        = ex_rt_q;
  assign MEM_Dest     = mem_rw_q ? mem_dest_q : ZERO_REG;
  assign WB_Dest      = wb_rw_q ? wb_dest_q : ZERO_REG;
  assign MEM_RegWrite = mem_rw_q;
  assign WB_RegWrite  = wb_rw_q;
  assign Stall        = stall_s;
  assign PC_Write     = ~stall_s;
  assign IFID_Write   = ~stall_s;
  assign Stall_Count  = cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Self-checking bench for hazard_pipe_tracker: vector table with a scoreboard
// queue, plus hand-written load-use, saturation and reset-mid-stall sequences.
module tb_hazard_pipe_tracker;

  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk;
  logic          reset;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          id_ut, id_rw, id_mr, id_v, flush;
  logic [AW-1:0] ex_rs, ex_rt, mem_dest, wb_dest;
  logic          mem_rw, wb_rw, stall, pc_write, ifid_write;
  logic [CW-1:0] stall_count;

  int n_tests;
  int n_fail;
  int exp_cnt;

  hazard_pipe_tracker #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_ut), .ID_Dest(id_dest),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_Valid(id_v), .Flush(flush),
    .EX_Rs(ex_rs), .EX_Rt(ex_rt), .MEM_Dest(mem_dest), .WB_Dest(wb_dest),
    .MEM_RegWrite(mem_rw), .WB_RegWrite(wb_rw), .Stall(stall),
    .PC_Write(pc_write), .IFID_Write(ifid_write), .Stall_Count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rs, rt, dest;
    logic          ut, rw, mr, v, fl;
    logic          stall;
    logic [AW-1:0] ex_rs, ex_rt, mem_d, wb_d;
    int            cnt;
  } vec_t;

  vec_t tbl[20];
  vec_t sb[$];

  function automatic vec_t mk(input int rs, rt, ut, dest, rw, mr, v, fl,
                              input int st, exrs, exrt, memd, wbd, cnt);
    vec_t r;
    r.rs = AW'(rs); r.rt = AW'(rt); r.ut = ut[0]; r.dest = AW'(dest);
    r.rw = rw[0]; r.mr = mr[0]; r.v = v[0]; r.fl = fl[0];
    r.stall = st[0]; r.ex_rs = AW'(exrs); r.ex_rt = AW'(exrt);
    r.mem_d = AW'(memd); r.wb_d = AW'(wbd); r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int rs, rt, ut, dest, rw, mr, v, fl);
    id_rs = AW'(rs); id_rt = AW'(rt); id_ut = ut[0]; id_dest = AW'(dest);
    id_rw = rw[0]; id_mr = mr[0]; id_v = v[0]; flush = fl[0];
  endtask

  // One decode cycle with expected stall; the bench tracks the saturating count itself
  task automatic cyc(input int rs, rt, ut, dest, rw, mr, v, fl, input int exp_st, input string nm);
    @(negedge clk);
    drive(rs, rt, ut, dest, rw, mr, v, fl);
    #1;
    check({nm, " stall"}, int'(stall), exp_st);
    check({nm, " pc_write"}, int'(pc_write), 1 - exp_st);
    if (exp_st != 0 && exp_cnt < CMAX) exp_cnt++;
    @(posedge clk);
    #1;
    check({nm, " count"}, int'(stall_count), exp_cnt);
  endtask

  initial begin
    vec_t e;
    n_tests = 0;
    n_fail  = 0;

    //             rs rt ut de rw mr v fl | st exrs exrt memd wbd cnt
    tbl[0]  = mk( 9,10, 1, 8, 1, 0, 1, 0,   0,  9, 10,  0,  0, 0);
    tbl[1]  = mk( 0, 0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  8,  0, 0);
    tbl[2]  = mk( 0, 0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  8, 0);
    tbl[3]  = mk( 3, 8, 0, 8, 1, 1, 1, 0,   0,  3,  8,  0,  0, 0);
    tbl[4]  = mk( 8, 4, 1,12, 1, 0, 1, 0,   1,  0,  0,  8,  0, 1);
    tbl[5]  = mk( 8, 4, 1,12, 1, 0, 1, 0,   0,  8,  4,  0,  8, 1);
    tbl[6]  = mk( 3, 8, 0, 8, 1, 1, 1, 0,   0,  3,  8, 12,  0, 1);
    tbl[7]  = mk( 5, 8, 0, 6, 1, 0, 1, 0,   0,  5,  8,  8, 12, 1);
    tbl[8]  = mk( 2, 0, 0, 0, 1, 1, 1, 0,   0,  2,  0,  6,  8, 1);
    tbl[9]  = mk( 0, 0, 1, 7, 1, 0, 1, 0,   0,  0,  0,  0,  6, 1);
    tbl[10] = mk( 9, 5, 1, 5, 0, 0, 1, 0,   0,  9,  5,  7,  0, 1);
    tbl[11] = mk( 0, 0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  7, 1);
    tbl[12] = mk( 0, 0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0, 1);
    tbl[13] = mk( 1, 9, 0, 9, 1, 1, 1, 0,   0,  1,  9,  0,  0, 1);
    tbl[14] = mk( 4, 9, 1,10, 1, 0, 1, 1,   0,  0,  0,  9,  0, 1);
    tbl[15] = mk( 0, 0, 0,11, 1, 1, 0, 0,   0,  0,  0,  0,  9, 1);
    tbl[16] = mk(11, 0, 0, 3, 1, 0, 1, 0,   0, 11,  0,  0,  0, 1);
    tbl[17] = mk( 2,13, 0,13, 1, 1, 1, 0,   0,  2, 13,  3,  0, 1);
    tbl[18] = mk( 1,13, 1,14, 1, 0, 1, 0,   1,  0,  0, 13,  3, 2);
    tbl[19] = mk( 1,13, 1,14, 1, 0, 1, 0,   0,  1, 13,  0, 13, 2);

    // Reset held two cycles with random decode inputs
    reset = 1'b1;
    drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    @(posedge clk);
    @(negedge clk);
    drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    @(posedge clk);
    #1;
    check("rst ex_rs", int'(ex_rs), 0);
    check("rst ex_rt", int'(ex_rt), 0);
    check("rst mem_dest", int'(mem_dest), 0);
    check("rst wb_dest", int'(wb_dest), 0);
    check("rst mem_rw", int'(mem_rw), 0);
    check("rst wb_rw", int'(wb_rw), 0);
    check("rst stall", int'(stall), 0);
    check("rst pc_write", int'(pc_write), 1);
    check("rst ifid_write", int'(ifid_write), 1);
    check("rst count", int'(stall_count), 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Table vectors: stall checked before the edge, stage outputs via the scoreboard after it
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].dest, tbl[i].rw, tbl[i].mr, tbl[i].v, tbl[i].fl);
      #1;
      check($sformatf("v%0d stall", i), int'(stall), int'(tbl[i].stall));
      check($sformatf("v%0d pc_write", i), int'(pc_write), int'(!tbl[i].stall));
      check($sformatf("v%0d ifid_write", i), int'(ifid_write), int'(!tbl[i].stall));
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d ex_rs", i), int'(ex_rs), int'(e.ex_rs));
      check($sformatf("v%0d ex_rt", i), int'(ex_rt), int'(e.ex_rt));
      check($sformatf("v%0d mem_dest", i), int'(mem_dest), int'(e.mem_d));
      check($sformatf("v%0d wb_dest", i), int'(wb_dest), int'(e.wb_d));
      check($sformatf("v%0d count", i), int'(stall_count), e.cnt);
    end
    exp_cnt = 2;

    // Back-to-back loads feeding each other: one stall per pair
    cyc(0, 5, 0, 5, 1, 1, 1, 0, 0, "b2b lw5");
    cyc(5, 6, 0, 6, 1, 1, 1, 0, 1, "b2b lw6 use");
    cyc(5, 6, 0, 6, 1, 1, 1, 0, 0, "b2b lw6 go");
    cyc(6, 6, 1, 7, 1, 0, 1, 0, 1, "b2b add use");
    cyc(6, 6, 1, 7, 1, 0, 1, 0, 0, "b2b add go");

    // Saturation: repeated load-use pairs past the counter maximum
    for (int p = 0; p < 14; p++) begin
      cyc(3, 8, 0, 8, 1, 1, 1, 0, 0, "sat lw");
      cyc(8, 2, 1, 9, 1, 0, 1, 0, 1, "sat use");
      cyc(8, 2, 1, 9, 1, 0, 1, 0, 0, "sat go");
    end
    check("sat final count", int'(stall_count), CMAX);

    // Reset asserted while a stall is active
    cyc(3, 8, 0, 8, 1, 1, 1, 0, 0, "mid lw");
    @(negedge clk);
    drive(8, 2, 1, 9, 1, 0, 1, 0);
    #1;
    check("mid stall before", int'(stall), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid stall after", int'(stall), 0);
    check("mid ex_rs", int'(ex_rs), 0);
    check("mid ex_rt", int'(ex_rt), 0);
    check("mid mem_dest", int'(mem_dest), 0);
    check("mid count", int'(stall_count), 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
